// File: rtl/st_io_master.sv
// st_io_master: initiator on the ST programming bus.
// Accepts one read/write command at a time, runs a single bus transfer to the
// slave selected by cmd_addr[31:16], and returns exactly one response.
module st_io_master #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned WR_CYCLES  = 2,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                  io_clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [1:0]            rsp_err,
  output logic [NUM_SLAVES-1:0] io_sel,
  output logic                  io_sync,
  output logic [15:0]           io_addr,
  output logic                  io_rd_en,
  output logic                  io_wr_en,
  output logic [31:0]           io_wr_data,
  input  logic [31:0]           io_rd_data,
  input  logic                  io_rd_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_IDX = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  localparam logic [7:0] WR_LIM = 8'(WR_CYCLES);
  localparam logic [7:0] RD_LIM = 8'(RD_TIMEOUT);

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_data_q;
  logic [1:0]              rsp_err_q;
  logic [NUM_SLAVES-1:0]   io_sel_q;
  logic                    io_sync_q;
  logic [15:0]             io_addr_q;
  logic                    io_rd_en_q;
  logic                    io_wr_en_q;
  logic [31:0]             io_wr_data_q;
  logic [7:0]              cnt_q;

  logic [15:0]             cmd_idx;
  logic                    idx_ok;
  logic                    accept;
  logic [NUM_SLAVES-1:0]   sel_dec;
  logic                    wait_done;
  logic [1:0]              wait_err;
  logic [31:0]             wait_data;

  assign cmd_idx = cmd_addr[31:16];
  assign idx_ok  = 32'(cmd_idx) < NUM_SLAVES;
  assign accept  = cmd_valid && cmd_ready_q;

  // One-hot decode of the slave index from the incoming command.
  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_dec[i] = (32'(cmd_idx) == i);
    end
  end

  // WAIT-state completion: write hold expiry, read ack (wins over timeout), or timeout.
  always_comb begin
    wait_done = 1'b0;
    wait_err  = ERR_OK;
    wait_data = '0;
    if (io_wr_en_q) begin
      if (cnt_q == WR_LIM) begin
        wait_done = 1'b1;
      end
    end else if (io_rd_ack) begin
      wait_done = 1'b1;
      wait_data = io_rd_data;
    end else if (cnt_q == RD_LIM) begin
      wait_done = 1'b1;
      wait_err  = ERR_TMO;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= '0;
      io_sel_q     <= '0;
      io_sync_q    <= 1'b0;
      io_addr_q    <= '0;
      io_rd_en_q   <= 1'b0;
      io_wr_en_q   <= 1'b0;
      io_wr_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (!idx_ok) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_IDX;
              rsp_data_q  <= '0;
              state_q     <= ST_RESP;
            end else begin
              io_sync_q    <= 1'b1;
              io_sel_q     <= sel_dec;
              io_addr_q    <= cmd_addr[15:0];
              io_wr_data_q <= cmd_wr_data;
              io_rd_en_q   <= !cmd_wr;
              io_wr_en_q   <= cmd_wr;
              state_q      <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          io_sync_q <= 1'b0;
          cnt_q     <= 8'd1;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
          if (wait_done) begin
            io_sel_q     <= '0;
            io_addr_q    <= '0;
            io_rd_en_q   <= 1'b0;
            io_wr_en_q   <= 1'b0;
            io_wr_data_q <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= wait_err;
            rsp_data_q   <= wait_data;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign io_sel     = io_sel_q;
  assign io_sync    = io_sync_q;
  assign io_addr    = io_addr_q;
  assign io_rd_en   = io_rd_en_q;
  assign io_wr_en   = io_wr_en_q;
  assign io_wr_data = io_wr_data_q;

endmodule

// File: tb/tb_st_io_master.sv
// Testbench for st_io_master: directed vector table, hand-written reset
// sequences, and randomized commands checked against a transaction-level model.
module tb_st_io_master;

  localparam int NUM = 4;
  localparam int WRC = 2;
  localparam int RDT = 255;

  logic        io_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [3:0]  io_sel;
  logic        io_sync;
  logic [15:0] io_addr;
  logic        io_rd_en;
  logic        io_wr_en;
  logic [31:0] io_wr_data;
  logic [31:0] io_rd_data;
  logic        io_rd_ack;

  int checks = 0;
  int errors = 0;

  st_io_master #(
    .NUM_SLAVES(NUM),
    .WR_CYCLES (WRC),
    .RD_TIMEOUT(RDT)
  ) dut (
    .io_clk     (io_clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .io_sel     (io_sel),
    .io_sync    (io_sync),
    .io_addr    (io_addr),
    .io_rd_en   (io_rd_en),
    .io_wr_en   (io_wr_en),
    .io_wr_data (io_wr_data),
    .io_rd_data (io_rd_data),
    .io_rd_ack  (io_rd_ack)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_k;   // ack in WAIT cycle k (1 = first); 0 = never
    logic [31:0] rdata;
    int          hold;    // cycles rsp_ready stays low after rsp_valid
    int          exp_lat; // accept edge to rsp_valid, in cycles
    logic [3:0]  exp_sel;
    logic [1:0]  exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome derived from the bus protocol rules.
  function automatic void model(input logic wr, input logic [31:0] addr, input int k,
                                input logic [31:0] rdata, output int lat,
                                output logic [3:0] sel, output logic [1:0] err,
                                output logic [31:0] data);
    int idx;
    idx = int'(addr[31:16]);
    if (idx >= NUM) begin
      lat = 1; sel = 4'b0000; err = 2'd1; data = 32'h0;
    end else begin
      sel = 4'(1 << idx);
      if (wr) begin
        lat = 2 + WRC; err = 2'd0; data = 32'h0;
      end else if (k >= 1 && k <= RDT) begin
        lat = 2 + k; err = 2'd0; data = rdata;
      end else begin
        lat = 2 + RDT; err = 2'd2; data = 32'h0;
      end
    end
  endfunction

  // Issue one command acting as the slave, then check bus activity and response.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_k, input logic [31:0] rdata, input int hold,
                         input int exp_lat, input logic [3:0] exp_sel,
                         input logic [1:0] exp_err, input logic [31:0] exp_data);
    int wait_n, cyc, syncs, selc, bus_bad, lat, hold_bad;
    logic [31:0] d0;
    logic [1:0]  e0;
    wait_n = 0; syncs = 0; selc = 0; bus_bad = 0; lat = 0; hold_bad = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wr_data = wdata;
    while (!cmd_ready && wait_n < 20) begin
      @(negedge io_clk);
      wait_n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge io_clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cyc = 1;
    while (cyc <= 400) begin
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (io_sync) syncs++;
      if (io_sel != 4'b0000) begin
        selc++;
        if (io_sel !== exp_sel || io_addr !== addr[15:0] || io_wr_en !== wr ||
            io_rd_en !== ~wr || (wr && io_wr_data !== wdata)) bus_bad++;
      end
      if (cmd_ready) bus_bad++;
      if (!wr && ack_k > 0 && cyc == ack_k + 1) begin
        io_rd_ack  = 1'b1;
        io_rd_data = rdata;
      end else begin
        io_rd_ack  = (wr || cyc == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        io_rd_data = $urandom;
      end
      @(negedge io_clk);
      cyc++;
    end
    io_rd_ack = 1'b0;
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    if (lat == 0) return;
    check("sync_pulses", 32'(syncs), (exp_sel == 4'b0000) ? 32'd0 : 32'd1);
    check("sel_cycles", 32'(selc), (exp_sel == 4'b0000) ? 32'd0 : 32'(exp_lat - 1));
    check("bus_fields", 32'(bus_bad), 32'd0);
    check("bus_idle_at_rsp", 32'({io_sel, io_sync, io_rd_en, io_wr_en}), 32'd0);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_data", rsp_data, exp_data);
    d0 = rsp_data; e0 = rsp_err;
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_wr = 1'($urandom_range(0, 1));
      cmd_addr = 32'h0000_0010; cmd_wr_data = $urandom;
      for (int i = 0; i < hold; i++) begin
        @(negedge io_clk);
        if (!rsp_valid || cmd_ready || rsp_data !== d0 || rsp_err !== e0) hold_bad++;
      end
      check("rsp_hold_stable", 32'(hold_bad), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge io_clk);
    rsp_ready = 1'b0;
    check("rsp_handshake", 32'({rsp_valid, cmd_ready}), 32'b01);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge io_clk);
    check("reset_outputs", 32'(|{cmd_ready, rsp_valid, rsp_data, rsp_err, io_sel, io_sync,
                                 io_addr, io_rd_en, io_wr_en, io_wr_data}), 32'd0);
    reset = 1'b0;
    @(negedge io_clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [3:0]  sel;
    logic [1:0]  err;
    logic [31:0] data, addr, wdata, rdata;
    logic        wr;
    int          k, r;

    //         wr    addr           wdata          k    rdata          hold lat  sel      err   data
    tbl[0] = '{1'b1, 32'h0002_0010, 32'hDEADBEEF, 0,   32'h0,         0,   4,   4'b0100, 2'd0, 32'h0};
    tbl[1] = '{1'b0, 32'h0001_0004, 32'h0,        5,   32'h12345678,  0,   7,   4'b0010, 2'd0, 32'h12345678};
    tbl[2] = '{1'b0, 32'h0000_0000, 32'h0,        0,   32'h0,         0,   257, 4'b0001, 2'd2, 32'h0};
    tbl[3] = '{1'b0, 32'h0007_0000, 32'h0,        0,   32'h0,         0,   1,   4'b0000, 2'd1, 32'h0};
    tbl[4] = '{1'b1, 32'h0003_00AA, 32'hCAFEF00D, 0,   32'h0,         10,  4,   4'b1000, 2'd0, 32'h0};
    tbl[5] = '{1'b0, 32'h0003_ABCD, 32'h0,        1,   32'hA5A5A5A5,  2,   3,   4'b1000, 2'd0, 32'hA5A5A5A5};
    tbl[6] = '{1'b1, 32'h0004_0000, 32'h11111111, 0,   32'h0,         1,   1,   4'b0000, 2'd1, 32'h0};
    tbl[7] = '{1'b0, 32'h0002_0100, 32'h0,        255, 32'h0F0F0F0F,  0,   257, 4'b0100, 2'd0, 32'h0F0F0F0F};
    tbl[8] = '{1'b0, 32'h0001_0008, 32'h0,        256, 32'h00000077,  0,   257, 4'b0010, 2'd2, 32'h0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
    rsp_ready = 1'b0; io_rd_data = '0; io_rd_ack = 1'b0;
    @(negedge io_clk);
    apply_reset();

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ack_k, tbl[i].rdata, tbl[i].hold,
              tbl[i].exp_lat, tbl[i].exp_sel, tbl[i].exp_err, tbl[i].exp_data);
    end

    // Reset while a read sits in WAIT: bus drops at once and no response follows.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0001_0020; cmd_wr_data = 32'h0;
    @(negedge io_clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge io_clk);
    check("mid_read_active", 32'({io_sel, io_rd_en}), 32'({4'b0010, 1'b1}));
    reset = 1'b1;
    @(negedge io_clk);
    check("abort_bus_zero", 32'(|{io_sel, io_sync, io_addr, io_rd_en, io_wr_en, io_wr_data}), 32'd0);
    check("abort_no_rsp", 32'({rsp_valid, cmd_ready}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge io_clk);
    check("abort_idle_after", 32'({rsp_valid, cmd_ready}), 32'b01);
    run_cmd(1'b1, 32'h0000_0044, 32'h5555AAAA, 0, 32'h0, 0, 4, 4'b0001, 2'd0, 32'h0);

    // Randomized commands against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = {16'($urandom_range(0, 5)), 16'($urandom)};
      wdata = $urandom;
      rdata = $urandom;
      r     = int'($urandom_range(0, 19));
      if (r == 0)      k = 0;
      else if (r == 1) k = RDT;
      else             k = int'($urandom_range(1, 12));
      model(wr, addr, k, rdata, lat, sel, err, data);
      run_cmd(wr, addr, wdata, k, rdata, int'($urandom_range(0, 3)), lat, sel, err, data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/st_io_master.md
Name: st_io_master

Overview:
- Initiator side of the ST programming bus: accepts single read/write commands on a valid/ready port and drives io_sel/io_sync/io_addr/io_rd_en/io_wr_en/io_wr_data toward the slave blocks.
- Collects io_rd_data/io_rd_ack from the selected slave, or detects a timeout, and returns one response per command.
- Sits between the host link/command decoder and the per-module slave I/O blocks; bits [31:16] of the command address select the slave, bits [15:0] pass through as io_addr.

Parameters:
- NUM_SLAVES, 4, number of slave select lines; slave index = cmd_addr[31:16].
- WR_CYCLES, 2, cycles io_sel/io_wr_en are held after io_sync on a write (1..15).
- RD_TIMEOUT, 255, max cycles to wait for io_rd_ack after io_sync (1..255).

Ports:
- io_clk  in  1  programming clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  [31:16] slave index, [15:0] slave address
- cmd_wr_data  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  32  read data (0 for writes and errors)
- rsp_err  out  2  0 = ok, 1 = bad slave index, 2 = read timeout
- io_sel  out  NUM_SLAVES  one-hot slave select
- io_sync  out  1  one-cycle start pulse
- io_addr  out  16  slave address
- io_rd_en  out  1  read operation
- io_wr_en  out  1  write operation
- io_wr_data  out  32  write data
- io_rd_data  in  32  OR-combined slave read data
- io_rd_ack  in  1  OR-combined slave read acknowledge

Behaviour:
- Reset (sync, active-high): state IDLE; cmd_ready=0 during reset, 1 the first cycle after reset is released; rsp_valid=0, rsp_data=0, rsp_err=0, io_sel=0, io_sync=0, io_rd_en=0, io_wr_en=0, io_addr=0, io_wr_data=0; counters cleared. Reset asserted mid-transaction aborts it: all bus outputs are 0 on the cycle after reset is sampled, and no response is issued.
- States: IDLE, SYNC, WAIT, RESP.
- IDLE: cmd_ready=1. On accept, latch the command.
  - Slave index >= NUM_SLAVES: go to RESP with rsp_err=1 and rsp_data=0. No bus activity.
  - Otherwise go to SYNC.
- SYNC (1 cycle): io_sync=1; io_sel=one-hot(index); io_addr, io_wr_data, io_rd_en=!cmd_wr and io_wr_en=cmd_wr all valid. Next state is WAIT; the counter loads 1.
- WAIT: io_sync=0; io_sel, io_addr, io_rd_en/io_wr_en and io_wr_data stay held.
  - Write: when the counter reaches WR_CYCLES, deassert io_sel/io_wr_en and go to RESP with err=0, data=0.
  - Read: if io_rd_ack=1, capture io_rd_data into rsp_data, deassert io_sel/io_rd_en and go to RESP with err=0.
  - Read with no ack: when the counter reaches RD_TIMEOUT, go to RESP with err=2, data=0.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready. On handshake, clear rsp_valid and return to IDLE. cmd_ready=0 throughout.
- Throughput: one outstanding command.
- Minimum command-accept to rsp_valid latency:
  - write = 2+WR_CYCLES cycles;
  - read with ack in the first WAIT cycle = 3 cycles;
  - bad index = 1 cycle.
- io_rd_ack outside WAIT, or during a write, is ignored.
- The counter is 8 bits and saturates; no wrap.
- All outputs are registered.

Test Plan:
- Reset, then write cmd addr=0x0002_0010, data=0xDEADBEEF -> one io_sync pulse; io_sel=4'b0100, io_addr=0x0010, io_wr_en=1 held for 1+WR_CYCLES=3 cycles; rsp_valid with err=0, data=0.
- Read addr=0x0001_0004; slave acks after 5 cycles with 0x12345678 -> io_rd_en/io_sel=4'b0010 held until the ack; rsp_data=0x12345678, err=0; bus idle the next cycle.
- Read addr=0x0000_0000 with no ack -> rsp err=2 exactly RD_TIMEOUT=255 cycles after the WAIT entry; io_sel drops together with rsp_valid rising.
- Command addr=0x0007_0000 (index >= 4) -> no io_sync; rsp err=1 one cycle after accept.
- Hold rsp_ready=0 for 10 cycles with a new cmd_valid pending -> cmd_ready stays 0 and rsp fields stay stable; the next command is accepted only after the response handshake.
- Assert reset during WAIT of a read -> all io_* outputs 0 the next cycle; no rsp_valid; a following write completes normally.
